// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the serial signed subtractor.
// The overflow rule lives here so every user evaluates it the same way.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DIGIT = 1;

  // Signed overflow of A - B: operand signs differ and the result sign
  // disagrees with the minuend sign.
  function automatic logic sub_overflow(input logic sa, input logic sb, input logic diff_msb);
    return (sa != sb) && (diff_msb != sa);
  endfunction

endpackage

// File: rtl/ripple_digit_add.sv
// DIGIT-bit combinational full-adder chain used as the per-cycle adder slice
// of the serial subtractor.
module ripple_digit_add #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout
);

  logic [DIGIT:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s[i]     = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign cout = w_c[DIGIT];

endmodule

// File: rtl/serial_subtractor32signed.sv
// Serial signed subtractor: A - B - Bin computed DIGIT bits per cycle, LSB
// first, as A + ~B + ~Bin; results are returned over a valid/ready handshake.
//
// Handshakes: an operand transfer happens on a rising edge where
// in_valid && in_ready; a result transfer happens on a rising edge where
// out_valid && out_ready. in_ready and out_valid are decoded from the state
// register only, so neither depends combinationally on any input.
module serial_subtractor32signed
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             Bout,
  output logic             overflow,
  output state_t           o_dbg_state
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NDIG - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_r_sr;
  logic [WIDTH-1:0] r_diff;
  logic             r_carry;
  logic             r_bout;
  logic             r_ovf;
  logic             r_sa;
  logic             r_sb;
  logic [CW-1:0]    r_cnt;

  logic [DIGIT-1:0] w_s;
  logic             w_c;
  logic             w_accept;
  logic             w_run;
  logic             w_last;
  logic [WIDTH-1:0] w_result;

  ripple_digit_add #(
    .DIGIT(DIGIT)
  ) u_digit_add (
    .a    (r_a_sr[DIGIT-1:0]),
    .b    (r_b_sr[DIGIT-1:0]),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_c)
  );

  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_run    = (r_state == RUN);
  assign w_last   = w_run && (r_cnt == LAST_CNT);
  // New digit enters at the top; after NDIG shifts the LSB digit sits at bit 0.
  assign w_result = {w_s, r_r_sr[WIDTH-1:DIGIT]};

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next_state = RUN;
      RUN:     if (r_cnt == LAST_CNT) w_next_state = DONE;
      DONE:    if (out_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_r_sr  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      // Subtraction as addition of the complemented subtrahend and borrow.
      r_a_sr  <= A;
      r_b_sr  <= ~B;
      r_carry <= ~Bin;
      r_sa    <= A[WIDTH-1];
      r_sb    <= B[WIDTH-1];
      r_cnt   <= '0;
    end else if (w_run) begin
      r_a_sr  <= r_a_sr >> DIGIT;
      r_b_sr  <= r_b_sr >> DIGIT;
      r_r_sr  <= w_result;
      r_carry <= w_c;
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        r_diff <= w_result;
        r_bout <= ~w_c;
        r_ovf  <= sub_overflow(r_sa, r_sb, w_result[WIDTH-1]);
      end
    end
  end

  assign in_ready    = (r_state == IDLE);
  assign out_valid   = (r_state == DONE);
  assign diff        = r_diff;
  assign Bout        = r_bout;
  assign overflow    = r_ovf;
  assign o_dbg_state = r_state;

endmodule

// File: doc/serial_subtractor32signed.md
# serial_subtractor32signed

Sequential signed subtractor: the inverse operation of the 32-bit signed ripple adder datapath. It accepts two's-complement operands A, B and a borrow-in, and computes A − B − Bin over WIDTH/DIGIT clock cycles, DIGIT bits per cycle, LSB first. It returns the difference, borrow-out and signed overflow through a valid/ready result handshake. It is the area-lean subtract path next to the combinational ripple adder in the arithmetic lab datapath.

## Interface
Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 1, bits processed per cycle; allowed values 1, 2, 4, 8.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- in_valid  input  1  operands presented.
- in_ready  output  1  block can accept operands; high only in IDLE.
- A  input  WIDTH  signed minuend.
- B  input  WIDTH  signed subtrahend.
- Bin  input  1  borrow-in.
- out_valid  output  1  result registers hold a completed result.
- out_ready  input  1  consumer accepts the result.
- diff  output  WIDTH  signed difference, A − B − Bin mod 2^WIDTH.
- Bout  output  1  borrow-out; 1 iff unsigned A < unsigned B + Bin.
- overflow  output  1  signed overflow of the subtraction.

## Operation
- States are IDLE, RUN and DONE. `in_ready = (state==IDLE)` and `out_valid = (state==DONE)`.
- IDLE: on `in_valid && in_ready`, the block:
  - captures A into the operand shift register a_sr;
  - captures ~B into b_sr;
  - sets carry = ~Bin;
  - captures sign flags sa = A[WIDTH-1] and sb = B[WIDTH-1];
  - clears the digit counter cnt;
  - moves to RUN.
- RUN, every cycle:
  - `{c, s} = a_sr[DIGIT-1:0] + b_sr[DIGIT-1:0] + carry`.
  - a_sr and b_sr shift right by DIGIT.
  - s shifts into the top of the result register r_sr.
  - carry takes c, and cnt increments.
  - When cnt = WIDTH/DIGIT−1: load `diff <= {s, r_sr[WIDTH-1:DIGIT]}` and `Bout <= ~c`; load `overflow <= (sa != sb) && (final diff MSB != sa)`; move to DONE.
- DONE: diff, Bout and overflow are held stable. On `out_ready`, move to IDLE.
- diff, Bout and overflow keep their last value after the handshake until the next result loads.
- in_valid is ignored outside IDLE. Operands change freely once accepted.
- Arithmetic is modulo 2^WIDTH, with no sign extension internally. cnt is $clog2(WIDTH/DIGIT) bits wide, with a minimum of 1.
- Reset (rst_n low at an edge) puts the block in IDLE and clears diff, Bout, overflow, a_sr, b_sr, r_sr, carry and cnt to 0.
  - This applies in any state.
  - An in-flight or unconsumed result is discarded, and no out_valid pulse follows.
  - While rst_n is low, in_valid is not accepted.

## Timing
- Reset values after a reset edge:
  - in_ready = 1
  - out_valid = 0
  - diff = 0
  - Bout = 0
  - overflow = 0
- Latency: accept at edge E0; out_valid is high in the cycle after edge E0+WIDTH/DIGIT. For the defaults that is 32 cycles; for DIGIT=4 it is 8.
- Result handshake at edge Ek: out_valid low and in_ready high in the cycle after Ek.
  - There is no same-cycle accept of a new operand during DONE.
  - Minimum issue interval is WIDTH/DIGIT+2 cycles.
- out_ready held low keeps DONE indefinitely with stable outputs.
- out_ready asserted early, during IDLE or RUN, has no effect.
- All outputs are registered or decoded from the state register only, with no input-to-output combinational path.

## Structure
- Package serial_sub_pkg holds:
  - the state enum {IDLE, RUN, DONE};
  - the default WIDTH and DIGIT constants;
  - a function for the overflow rule, reused by the bench's reference model.
- One sub-module, ripple_digit_add: a DIGIT-bit combinational full-adder chain with ports (a, b, cin, s, cout), instantiated once in the RUN datapath.

## Test plan
- A=5, B=3, Bin=0 -> diff=0x00000002, Bout=0, overflow=0; out_valid is first seen exactly 32 cycles after the accept edge.
- A=0x80000000, B=0x00000001, Bin=0 -> diff=0x7FFFFFFF, Bout=0, overflow=1.
- A=0, B=1, Bin=0 -> diff=0xFFFFFFFF, Bout=1, overflow=0. A=0x7FFFFFFF, B=0xFFFFFFFF, Bin=1 -> diff=0x7FFFFFFF, Bout=1, overflow=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE with in_valid=1 and new operands. Required: diff, Bout and overflow stay unchanged, in_ready stays 0, and the new operands are not accepted until the cycle after the out handshake.
- Reset mid-RUN: drive rst_n=0 for one edge at cycle 10 of an operation. Required: out_valid never rises for that operation, in_ready=1 and diff=0 on the next cycle, and a following A=−7 (0xFFFFFFF9), B=2 gives diff=0xFFFFFFF7, overflow=0.
- DIGIT=4 build: 1000 random operand/Bin triples are checked against the package reference model, with latency 8 cycles and random out_ready stalls.
